// File: rtl/reg_map_pkg.sv
// ----------------------------------------------------------------------------
// reg_map_pkg
//
// Purpose:
//    Shared definitions for the camera parameter store. The reader
//    (reg_reader) and the writer (reg_writer) both import this package, so
//    the RAM address layout and the register index map are defined in one
//    place only.
//
// Contents:
//    SYNC_BYTE_DEFAULT  default frame start marker for the host byte link
//    ADDR_W / DATA_W    RAM address and data widths
//    IDX/MODE/CAM       address field widths and bit offsets
//                       (address = {reg_idx[3:0], mode[1:0], cam})
//    REG_*              register index constants (WIDTH, DEPTH, T11..T33)
//    wr_state_t         writer FSM state encoding
//    make_addr()        packs the three address fields into a RAM address
// ----------------------------------------------------------------------------
package reg_map_pkg;

    // Frame start marker on the host byte link.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // RAM geometry.
    localparam int ADDR_W = 7;
    localparam int DATA_W = 25;

    // Address field layout: IDX[6:3], MODE[2:1], CAM[0].
    localparam int IDX_W    = 4;
    localparam int IDX_LSB  = 3;
    localparam int MODE_W   = 2;
    localparam int MODE_LSB = 1;
    localparam int CAM_W    = 1;
    localparam int CAM_LSB  = 0;

    // Register index map. Indices above REG_LAST may be written but the
    // reader never looks at them.
    localparam logic [IDX_W-1:0] REG_WIDTH = 4'd0;
    localparam logic [IDX_W-1:0] REG_DEPTH = 4'd1;
    localparam logic [IDX_W-1:0] REG_T11   = 4'd2;
    localparam logic [IDX_W-1:0] REG_T12   = 4'd3;
    localparam logic [IDX_W-1:0] REG_T13   = 4'd4;
    localparam logic [IDX_W-1:0] REG_T21   = 4'd5;
    localparam logic [IDX_W-1:0] REG_T22   = 4'd6;
    localparam logic [IDX_W-1:0] REG_T23   = 4'd7;
    localparam logic [IDX_W-1:0] REG_T31   = 4'd8;
    localparam logic [IDX_W-1:0] REG_T32   = 4'd9;
    localparam logic [IDX_W-1:0] REG_T33   = 4'd10;
    localparam logic [IDX_W-1:0] REG_LAST  = REG_T33;

    // Writer FSM states. ST_CSUM is only reachable when the checksum
    // feature is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_WRITE = 3'd4
    } wr_state_t;

    // Packs register index, mode and camera select into a RAM address.
    function automatic logic [ADDR_W-1:0] make_addr(
        input logic [IDX_W-1:0]  idx,
        input logic [MODE_W-1:0] mode,
        input logic [CAM_W-1:0]  cam
    );
        return {idx, mode, cam};
    endfunction

endpackage

// File: rtl/reg_writer_timeout.sv
// ----------------------------------------------------------------------------
// reg_writer_timeout
//
// Purpose:
//    Inter-byte timeout for the frame assembler. A loadable down-counter:
//    every accepted byte reloads it with TIMEOUT-1, and it counts down on
//    each cycle the writer is mid-frame without receiving a byte. The
//    terminal-count pulse fires on the TIMEOUT-th consecutive idle cycle.
//
// Parameters:
//    TIMEOUT  idle cycles allowed between bytes of one frame
//
// Ports:
//    clk    in   1  system clock
//    reset  in   1  synchronous reset, active-high (counter cleared to 0)
//    load   in   1  reload counter with TIMEOUT-1 (byte accepted)
//    en     in   1  count down this cycle (mid-frame, no byte accepted)
//    tc     out  1  terminal count: enabled and counter already at zero
// ----------------------------------------------------------------------------
module reg_writer_timeout #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Reload has priority over counting; the counter parks at zero so a
    // stale enable can never wrap it around.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = en && (count == '0);

endmodule

// File: rtl/reg_writer.sv
// ----------------------------------------------------------------------------
// reg_writer
//
// Purpose:
//    Write side of the camera parameter store. Takes framed commands from the
//    host byte link (UART receiver), assembles a 7-bit RAM address and a
//    25-bit data word, and issues a single-cycle write on the RAM write port.
//
//    Frame: SYNC, ADDR, D3, D2, D1, D0 [, CSUM]
//    Data word = {D3[0], D2, D1, D0}; D3[7:1] is ignored.
//    Address   = ADDR[6:0] = {reg_idx[3:0], mode[1:0], cam}; ADDR[7] must be 0.
//
// Configuration macro:
//    REG_WRITER_CHECKSUM_EN  when defined, a CSUM byte (XOR of ADDR..D0) is
//                            required and checked; when undefined the frame is
//                            six bytes and no checksum logic is built.
//
// Parameters:
//    TIMEOUT    idle cycles allowed between bytes of one frame
//    SYNC_BYTE  frame start marker
//
// Ports:
//    clk        in   1   system clock
//    i_reset    in   1   synchronous reset, active-high
//    i_data     in   8   received byte
//    i_valid    in   1   i_data valid this cycle
//    o_ready    out  1   byte accepted when i_valid && o_ready
//    o_addr_wr  out  7   RAM write address {reg_idx, mode, cam}
//    o_data_wr  out  25  RAM write data
//    o_we       out  1   RAM write enable, one-cycle pulse
//    o_done     out  1   frame committed (same cycle as o_we)
//    o_err      out  1   frame dropped (bad address, checksum or timeout)
//    o_busy     out  1   high whenever a frame is in progress
// ----------------------------------------------------------------------------
module reg_writer
    import reg_map_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 100000,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_addr_wr,
    output logic [DATA_W-1:0] o_data_wr,
    output logic              o_we,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy
);

    wr_state_t         state;
    wr_state_t         state_next;
    logic              accept;
    logic              frame_err;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              timeout_en;
    logic              timeout_tc;
`ifdef REG_WRITER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    // The only cycle a byte cannot be taken is the write cycle itself, so a
    // SYNC arriving right behind a frame waits exactly one cycle.
    assign accept = i_valid && o_ready;

    // The inter-byte timer runs only while a frame is partially received;
    // a byte landing on the terminal-count cycle reloads it instead.
    assign timeout_en = ((state == ST_ADDR) || (state == ST_DATA)
`ifdef REG_WRITER_CHECKSUM_EN
                         || (state == ST_CSUM)
`endif
                        ) && !accept;

    reg_writer_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (i_reset),
        .load  (accept),
        .en    (timeout_en),
        .tc    (timeout_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Error pulses are raised in the same cycle as the
    // offending byte or the expiring timeout, and the FSM drops back to IDLE.
    always_comb begin
        state_next = state;
        frame_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && (i_data == SYNC_BYTE)) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    if (i_data[7]) begin
                        frame_err  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else if (timeout_tc) begin
                    frame_err  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (byte_cnt == 2'd3) begin
`ifdef REG_WRITER_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_WRITE;
`endif
                    end
                end else if (timeout_tc) begin
                    frame_err  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`ifdef REG_WRITER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (i_data == csum_q) begin
                        state_next = ST_WRITE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (timeout_tc) begin
                    frame_err  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`endif
            ST_WRITE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame assembly. The address and data registers drive the RAM port
    // directly; they are complete before WRITE and cannot change during it
    // because no byte is accepted in that state.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            byte_cnt <= 2'd0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (accept) begin
            if ((state == ST_ADDR) && !i_data[7]) begin
                addr_q   <= i_data[ADDR_W-1:0];
                byte_cnt <= 2'd0;
            end else if (state == ST_DATA) begin
                data_q   <= {data_q[DATA_W-9:0], i_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

`ifdef REG_WRITER_CHECKSUM_EN
    // Running XOR of ADDR through D0, seeded by the address byte.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            csum_q <= 8'h00;
        end else if (accept) begin
            if (state == ST_ADDR) begin
                csum_q <= i_data;
            end else if (state == ST_DATA) begin
                csum_q <= csum_q ^ i_data;
            end
        end
    end
`endif

    assign o_ready   = (state != ST_WRITE);
    assign o_busy    = (state != ST_IDLE);
    assign o_we      = (state == ST_WRITE);
    assign o_done    = (state == ST_WRITE);
    assign o_err     = frame_err;
    assign o_addr_wr = addr_q;
    assign o_data_wr = data_q;

endmodule

// File: tb/tb_reg_writer.sv
// ----------------------------------------------------------------------------
// tb_reg_writer
//
// Purpose:
//    Self-checking bench for reg_writer. Stimulus tasks drive bytes and feed
//    a byte-level reference model that predicts write/error events into a
//    queue; an independent monitor pops that queue whenever the DUT raises
//    o_we or o_err. Honours REG_WRITER_CHECKSUM_EN for the frame format.
// ----------------------------------------------------------------------------
module tb_reg_writer;

    localparam int unsigned TIMEOUT   = 16;
    localparam logic [7:0]  SYNC      = 8'hA5;
`ifdef REG_WRITER_CHECKSUM_EN
    localparam int          FRAME_LEN = 7;
`else
    localparam int          FRAME_LEN = 6;
`endif

    typedef struct {
        bit          is_err;
        logic [6:0]  addr;
        logic [24:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [6:0]  o_addr_wr;
    logic [24:0] o_data_wr;
    logic        o_we;
    logic        o_done;
    logic        o_err;
    logic        o_busy;

    int checks = 0;
    int failures = 0;
    int we_count = 0;
    int ready_low = 0;
    int ready_run = 0;
    int ready_run_max = 0;

    exp_t       exp_q[$];
    logic [7:0] frame_q[$];

    reg_writer #(
        .TIMEOUT   (TIMEOUT),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_addr_wr (o_addr_wr),
        .o_data_wr (o_data_wr),
        .o_we      (o_we),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_busy    (o_busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Absolute time limit so a stuck DUT can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Reference model: interprets the accepted byte stream frame by frame.
    // 'gap' is the number of idle cycles preceding this byte.
    task automatic modelByte(input logic [7:0] b, input int gap);
        exp_t e;
        logic [7:0] x;
        if (frame_q.size() > 0 && gap >= int'(TIMEOUT)) begin
            e.is_err = 1'b1; e.addr = '0; e.data = '0;
            exp_q.push_back(e);
            frame_q.delete();
        end
        if (frame_q.size() == 0) begin
            if (b == SYNC) frame_q.push_back(b);
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == 2 && b[7]) begin
                e.is_err = 1'b1; e.addr = '0; e.data = '0;
                exp_q.push_back(e);
                frame_q.delete();
            end else if (frame_q.size() == FRAME_LEN) begin
                x = frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4] ^ frame_q[5];
                e.addr = frame_q[1][6:0];
                e.data = {frame_q[2][0], frame_q[3], frame_q[4], frame_q[5]};
                e.is_err = (FRAME_LEN == 7) ? (x != frame_q[FRAME_LEN-1]) : 1'b0;
                exp_q.push_back(e);
                frame_q.delete();
            end
        end
    endtask

    task automatic modelIdle(input int n);
        exp_t e;
        if (frame_q.size() > 0 && n >= int'(TIMEOUT)) begin
            e.is_err = 1'b1; e.addr = '0; e.data = '0;
            exp_q.push_back(e);
            frame_q.delete();
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit   taken;
        logic rdy;
        modelByte(b, gap);
        i_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        i_valid = 1'b1;
        i_data  = b;
        taken   = 1'b0;
        for (int t = 0; t < 8 && !taken; t++) begin
            @(negedge clk);
            rdy = o_ready;
            @(posedge clk); #1;
            taken = rdy;
        end
        i_valid = 1'b0;
        if (!taken) checkOutput("byte_accept_timeout", 32'(taken), 32'd1);
    endtask

    task automatic idleCycles(input int n);
        modelIdle(n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic sendFrame(input logic [6:0] addr, input logic [24:0] data, input int gap_max, input bit bad_csum);
        logic [7:0] bytes[6];
        logic [7:0] x;
        bytes[0] = SYNC;
        bytes[1] = {1'b0, addr};
        bytes[2] = {$urandom_range(0, 127), data[24]};
        bytes[3] = data[23:16];
        bytes[4] = data[15:8];
        bytes[5] = data[7:0];
        x = bytes[1] ^ bytes[2] ^ bytes[3] ^ bytes[4] ^ bytes[5];
        for (int i = 0; i < 6; i++) applyStimulus(bytes[i], $urandom_range(0, gap_max));
`ifdef REG_WRITER_CHECKSUM_EN
        applyStimulus(bad_csum ? (x ^ 8'h01) : x, $urandom_range(0, gap_max));
`else
        if (bad_csum) x = 8'h00;
`endif
    endtask

    task automatic doReset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        frame_q.delete();
    endtask

    // Scoreboard monitor: every o_we / o_err pulse must match the next
    // predicted event.
    always @(negedge clk) begin
        exp_t e;
        if (!i_reset) begin
            if (!o_ready) begin
                ready_low++;
                ready_run++;
                if (ready_run > ready_run_max) ready_run_max = ready_run;
            end else begin
                ready_run = 0;
            end
            if (o_we) we_count++;
            if (o_we || o_err) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", {30'd0, o_we, o_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        checkOutput("err_pulse", {30'd0, o_we, o_err}, 32'd1);
                    end else begin
                        checkOutput("we_pulse", {29'd0, o_we, o_done, o_err}, 32'd6);
                        checkOutput("wr_addr", 32'(o_addr_wr), 32'(e.addr));
                        checkOutput("wr_data", 32'(o_data_wr), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        int wc;
        int kind;
        logic [7:0] csum;

        $display("[TB] reg_writer bench start, frame length %0d", FRAME_LEN);
        doReset();

        // Reset state.
        @(negedge clk);
        checkOutput("rst_we",   32'(o_we), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_err",  32'(o_err), 32'd0);
        checkOutput("rst_addr", 32'(o_addr_wr), 32'd0);
        checkOutput("rst_data", 32'(o_data_wr), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;

        // Basic frame: addr 12, data 1000800.
        csum = 8'h12 ^ 8'h01 ^ 8'h00 ^ 8'h08 ^ 8'h00;
        checkOutput("csum_model", 32'(csum), 32'h1B);
        wc = we_count;
        applyStimulus(SYNC, 0); applyStimulus(8'h12, 0); applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0); applyStimulus(8'h08, 0); applyStimulus(8'h00, 0);
`ifdef REG_WRITER_CHECKSUM_EN
        applyStimulus(8'h1B, 0);
`endif
        // Write must be presented the cycle right after the last byte.
        @(negedge clk);
        checkOutput("latency_we", 32'(o_we), 32'd1);
        @(posedge clk); #1;
        checkOutput("basic_one_write", 32'(we_count - wc), 32'd1);

`ifdef REG_WRITER_CHECKSUM_EN
        // Same frame, wrong checksum.
        wc = we_count;
        applyStimulus(SYNC, 0); applyStimulus(8'h12, 0); applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0); applyStimulus(8'h08, 0); applyStimulus(8'h00, 0);
        applyStimulus(8'h1C, 0);
        idleCycles(2);
        checkOutput("bad_csum_no_write", 32'(we_count - wc), 32'd0);
`endif

        // Junk before a frame.
        wc = we_count;
        applyStimulus(8'h00, 1); applyStimulus(8'hFF, 0); applyStimulus(8'h3C, 2);
        sendFrame(7'h03, 25'h140, 0, 1'b0);
        idleCycles(2);
        checkOutput("junk_one_write", 32'(we_count - wc), 32'd1);

        // Bad address byte, then a good frame.
        applyStimulus(SYNC, 0); applyStimulus(8'h85, 0);
        idleCycles(1);
        checkOutput("bad_addr_idle", 32'(o_busy), 32'd0);
        sendFrame(7'h2A, 25'h1ABCDEF, 1, 1'b0);
        idleCycles(2);

        // Timeout fires on the TIMEOUT-th idle cycle.
        applyStimulus(SYNC, 0); applyStimulus(8'h20, 0);
        modelIdle(int'(TIMEOUT));
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            @(negedge clk);
            checkOutput($sformatf("tmo_err_c%0d", k), 32'(o_err), (k == int'(TIMEOUT)) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        checkOutput("tmo_busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;

        // A byte on the terminal cycle wins: no error, frame completes.
        wc = we_count;
        applyStimulus(SYNC, 0); applyStimulus(8'h20, 0);
        applyStimulus(8'h00, int'(TIMEOUT) - 1);
        applyStimulus(8'h11, int'(TIMEOUT) - 1);
        applyStimulus(8'h22, 0); applyStimulus(8'h33, 0);
`ifdef REG_WRITER_CHECKSUM_EN
        applyStimulus(8'h20 ^ 8'h00 ^ 8'h11 ^ 8'h22 ^ 8'h33, int'(TIMEOUT) - 1);
`endif
        idleCycles(2);
        checkOutput("tmo_edge_write", 32'(we_count - wc), 32'd1);

        // Reset mid-frame, then a full frame to 0x50.
        applyStimulus(SYNC, 0); applyStimulus(8'h31, 0);
        applyStimulus(8'h01, 0); applyStimulus(8'h77, 0);
        doReset();
        checkOutput("midrst_busy", 32'(o_busy), 32'd0);
        wc = we_count;
        sendFrame(7'h50, 25'h0123456, 0, 1'b0);
        idleCycles(2);
        checkOutput("midrst_one_write", 32'(we_count - wc), 32'd1);

        // Back-to-back frames with i_valid held high.
        wc = we_count;
        ready_low = 0;
        ready_run_max = 0;
        sendFrame(7'h05, 25'h0AAAAAA, 0, 1'b0);
        sendFrame(7'h7F, 25'h1555555, 0, 1'b0);
        idleCycles(3);
        checkOutput("b2b_writes", 32'(we_count - wc), 32'd2);
        checkOutput("b2b_ready_low", 32'(ready_low), 32'd2);
        checkOutput("b2b_ready_run", 32'(ready_run_max), 32'd1);

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: sendFrame(7'($urandom), 25'($urandom), 2, 1'b0);
                1: begin
                    applyStimulus(8'($urandom), $urandom_range(0, 3));
                    applyStimulus(8'($urandom), 0);
                    sendFrame(7'($urandom), 25'($urandom), 1, 1'b0);
                end
                2: begin
                    applyStimulus(SYNC, 0);
                    applyStimulus({1'b1, 7'($urandom)}, $urandom_range(0, 3));
                end
                3: begin
                    applyStimulus(SYNC, 0);
                    applyStimulus(8'($urandom_range(0, 127)), 0);
                    applyStimulus(8'($urandom), $urandom_range(int'(TIMEOUT) - 2, int'(TIMEOUT) + 3));
                    applyStimulus(8'($urandom), $urandom_range(0, 2));
                end
                default: sendFrame(7'($urandom), 25'($urandom), int'(TIMEOUT) - 1, 1'b1);
            endcase
        end
        idleCycles(int'(TIMEOUT) + 4);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
